// File: rtl/didactic_obi2apb_bridge_if.sv
// Bus bundles for the OBI-to-APB bridge: OBI side (bridge is slave) and APB side (bridge is master).
// Signal names keep the bridge-centric _i/_o suffixes of the original port list.
interface didactic_obi2apb_bridge_obi_if #(
    parameter int unsigned ObiAw  = 32,
    parameter int unsigned ObiDw  = 32,
    parameter int unsigned ObiIdw = 1
);
    logic                  obi_req_i;
    logic                  obi_gnt_o;
    logic [ObiAw-1:0]      obi_addr_i;
    logic                  obi_we_i;
    logic [ObiDw/8-1:0]    obi_be_i;
    logic [ObiDw-1:0]      obi_wdata_i;
    logic [ObiIdw-1:0]     obi_aid_i;
    logic                  obi_rvalid_o;
    logic                  obi_rready_i;
    logic [ObiDw-1:0]      obi_rdata_o;
    logic [ObiIdw-1:0]     obi_rid_o;
    logic                  obi_err_o;

    modport slave (
        input  obi_req_i, obi_addr_i, obi_we_i, obi_be_i, obi_wdata_i, obi_aid_i, obi_rready_i,
        output obi_gnt_o, obi_rvalid_o, obi_rdata_o, obi_rid_o, obi_err_o
    );

    modport master (
        output obi_req_i, obi_addr_i, obi_we_i, obi_be_i, obi_wdata_i, obi_aid_i, obi_rready_i,
        input  obi_gnt_o, obi_rvalid_o, obi_rdata_o, obi_rid_o, obi_err_o
    );
endinterface

interface didactic_obi2apb_bridge_apb_if #(
    parameter int unsigned ApbAw = 12,
    parameter int unsigned ObiDw = 32
);
    logic [ApbAw-1:0]      paddr_o;
    logic                  psel_o;
    logic                  penable_o;
    logic                  pwrite_o;
    logic [ObiDw-1:0]      pwdata_o;
    logic [ObiDw/8-1:0]    pstrb_o;
    logic [ObiDw-1:0]      prdata_i;
    logic                  pready_i;
    logic                  pslverr_i;

    modport master (
        output paddr_o, psel_o, penable_o, pwrite_o, pwdata_o, pstrb_o,
        input  prdata_i, pready_i, pslverr_i
    );

    modport slave (
        input  paddr_o, psel_o, penable_o, pwrite_o, pwdata_o, pstrb_o,
        output prdata_i, pready_i, pslverr_i
    );
endinterface

// File: rtl/didactic_obi2apb_bridge.sv
// Single-outstanding OBI-to-APB bridge with address-window check and ACCESS timeout.
// All OBI response outputs are registered; APB outputs are decoded from state and captured request.
module didactic_obi2apb_bridge #(
    parameter int unsigned      ObiAw         = 32,
    parameter int unsigned      ObiDw         = 32,
    parameter int unsigned      ObiIdw        = 1,
    parameter int unsigned      ApbAw         = 12,
    parameter logic [ObiAw-1:0] BaseAddr      = 32'h0101_0000,
    parameter int unsigned      TimeoutCycles = 255
) (
    input logic                          clk_i,
    input logic                          rst_i,
    didactic_obi2apb_bridge_obi_if.slave obi,
    didactic_obi2apb_bridge_apb_if.master apb
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETUP  = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] RESP   = 2'd3;

    localparam bit         TimeoutEn = (TimeoutCycles != 0);
    localparam logic [7:0] TermCnt   = 8'(TimeoutCycles - 1);

    logic [1:0]         r_state;
    logic [ApbAw-1:0]   r_addr;
    logic               r_we;
    logic [ObiDw/8-1:0] r_be;
    logic [ObiDw-1:0]   r_wdata;
    logic [ObiIdw-1:0]  r_rid;
    logic [ObiDw-1:0]   r_rdata;
    logic               r_err;
    logic [7:0]         r_cnt;

    logic w_in_window;
    logic w_psel;

    assign w_in_window = (obi.obi_addr_i[ObiAw-1:ApbAw] == BaseAddr[ObiAw-1:ApbAw]);
    assign w_psel      = (r_state == SETUP) || (r_state == ACCESS);

    // Grant is masked during reset so the reset value of gnt is 0 regardless of req.
    assign obi.obi_gnt_o    = obi.obi_req_i && (r_state == IDLE) && !rst_i;
    assign obi.obi_rvalid_o = (r_state == RESP);
    assign obi.obi_rdata_o  = r_rdata;
    assign obi.obi_rid_o    = r_rid;
    assign obi.obi_err_o    = r_err;

    assign apb.psel_o    = w_psel;
    assign apb.penable_o = (r_state == ACCESS);
    assign apb.paddr_o   = w_psel ? {r_addr[ApbAw-1:2], 2'b00} : '0;
    assign apb.pwrite_o  = w_psel && r_we;
    assign apb.pwdata_o  = w_psel ? r_wdata : '0;
    assign apb.pstrb_o   = (w_psel && r_we) ? r_be : '0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_be    <= '0;
            r_wdata <= '0;
            r_rid   <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (obi.obi_req_i) begin
                        r_addr  <= obi.obi_addr_i[ApbAw-1:0];
                        r_we    <= obi.obi_we_i;
                        r_be    <= obi.obi_be_i;
                        r_wdata <= obi.obi_wdata_i;
                        r_rid   <= obi.obi_aid_i;
                        r_cnt   <= '0;
                        if (w_in_window) begin
                            r_state <= SETUP;
                        end else begin
                            r_rdata <= '0;
                            r_err   <= 1'b1;
                            r_state <= RESP;
                        end
                    end
                end
                SETUP: begin
                    r_state <= ACCESS;
                end
                ACCESS: begin
                    r_cnt <= r_cnt + 8'd1;
                    // A completing slave takes priority over a timeout in the same cycle.
                    if (apb.pready_i) begin
                        r_rdata <= r_we ? '0 : apb.prdata_i;
                        r_err   <= apb.pslverr_i;
                        r_state <= RESP;
                    end else if (TimeoutEn && (r_cnt == TermCnt)) begin
                        r_rdata <= '0;
                        r_err   <= 1'b1;
                        r_state <= RESP;
                    end
                end
                RESP: begin
                    if (obi.obi_rready_i) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_didactic_obi2apb_bridge.sv
// Directed bench for didactic_obi2apb_bridge: one instance with an 8-cycle timeout,
// one with the timeout disabled.
module tb_didactic_obi2apb_bridge;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    didactic_obi2apb_bridge_obi_if #(.ObiAw(32), .ObiDw(32), .ObiIdw(1)) obi  ();
    didactic_obi2apb_bridge_apb_if #(.ApbAw(12), .ObiDw(32))             apb  ();
    didactic_obi2apb_bridge_obi_if #(.ObiAw(32), .ObiDw(32), .ObiIdw(1)) obi2 ();
    didactic_obi2apb_bridge_apb_if #(.ApbAw(12), .ObiDw(32))             apb2 ();

    didactic_obi2apb_bridge #(.TimeoutCycles(8)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .obi   (obi),
        .apb   (apb)
    );

    didactic_obi2apb_bridge #(.TimeoutCycles(0)) dut_nto (
        .clk_i (clk),
        .rst_i (rst),
        .obi   (obi2),
        .apb   (apb2)
    );

    int n_checks = 0;
    int n_errors = 0;

    // APB slave model state for the main instance
    int          slv_ws   = 0;
    bit          slv_hang = 1'b0;
    int          acc_cnt  = 0;
    int          pen_total  = 0;
    int          psel_total = 0;
    logic [11:0] su_paddr;
    logic        su_pwrite;
    logic [3:0]  su_pstrb;
    logic [31:0] su_pwdata;

    int lat;
    int p0;
    int e0;
    bit seen;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents a request in the current cycle (cycle 0), checks the grant, leaves in cycle 1.
    task automatic issue(input logic [31:0] addr, input logic we, input logic [3:0] be,
                         input logic [31:0] wdata, input logic aid);
        obi.obi_req_i   = 1'b1;
        obi.obi_addr_i  = addr;
        obi.obi_we_i    = we;
        obi.obi_be_i    = be;
        obi.obi_wdata_i = wdata;
        obi.obi_aid_i   = aid;
        @(negedge clk);
        check("gnt_cycle0", 32'(obi.obi_gnt_o), 32'd1);
        step();
        obi.obi_req_i = 1'b0;
    endtask

    // Called in cycle 1; returns at the negedge of the first rvalid cycle with its cycle number.
    task automatic wait_resp(input int limit, output int cyc);
        cyc = 1;
        while (1) begin
            @(negedge clk);
            if (obi.obi_rvalid_o) return;
            if (cyc >= limit) begin
                check("rvalid_wait", 32'd0, 32'd1);
                return;
            end
            step();
            cyc++;
        end
    endtask

    initial begin
        apb.pready_i = 1'b0;
        forever begin
            @(negedge clk);
            if (apb.psel_o && apb.penable_o) begin
                apb.pready_i = !slv_hang && (acc_cnt == slv_ws);
                acc_cnt++;
                pen_total++;
            end else begin
                apb.pready_i = 1'b0;
                acc_cnt = 0;
            end
            if (apb.psel_o) psel_total++;
            if (apb.psel_o && !apb.penable_o) begin
                su_paddr  = apb.paddr_o;
                su_pwrite = apb.pwrite_o;
                su_pstrb  = apb.pstrb_o;
                su_pwdata = apb.pwdata_o;
            end
        end
    end

    initial begin
        rst = 1'b1;
        obi.obi_req_i = 1'b1;
        obi.obi_addr_i = 32'h0101_0000;
        obi.obi_we_i = 1'b0;
        obi.obi_be_i = 4'h0;
        obi.obi_wdata_i = '0;
        obi.obi_aid_i = 1'b0;
        obi.obi_rready_i = 1'b1;
        apb.prdata_i = '0;
        apb.pslverr_i = 1'b0;
        obi2.obi_req_i = 1'b0;
        obi2.obi_addr_i = '0;
        obi2.obi_we_i = 1'b0;
        obi2.obi_be_i = 4'h0;
        obi2.obi_wdata_i = '0;
        obi2.obi_aid_i = 1'b0;
        obi2.obi_rready_i = 1'b1;
        apb2.prdata_i = '0;
        apb2.pready_i = 1'b0;
        apb2.pslverr_i = 1'b0;

        // Reset state, with req held high to show gnt is forced low
        step();
        step();
        @(negedge clk);
        check("rst_gnt",     32'(obi.obi_gnt_o),    32'd0);
        check("rst_rvalid",  32'(obi.obi_rvalid_o), 32'd0);
        check("rst_rdata",   obi.obi_rdata_o,       32'd0);
        check("rst_rid",     32'(obi.obi_rid_o),    32'd0);
        check("rst_err",     32'(obi.obi_err_o),    32'd0);
        check("rst_psel",    32'(apb.psel_o),       32'd0);
        check("rst_penable", 32'(apb.penable_o),    32'd0);
        check("rst_paddr",   32'(apb.paddr_o),      32'd0);
        check("rst_pstrb",   32'(apb.pstrb_o),      32'd0);
        step();
        rst = 1'b0;
        obi.obi_req_i = 1'b0;
        step();

        // Write in window, no wait states
        e0 = pen_total;
        slv_ws = 0;
        issue(32'h0101_0010, 1'b1, 4'hF, 32'hA5A5_5A5A, 1'b0);
        wait_resp(20, lat);
        check("wr_latency", 32'(lat),              32'd3);
        check("wr_err",     32'(obi.obi_err_o),    32'd0);
        check("wr_psel_rsp",32'(apb.psel_o),       32'd0);
        check("wr_paddr",   32'(su_paddr),         32'h010);
        check("wr_pwrite",  32'(su_pwrite),        32'd1);
        check("wr_pstrb",   32'(su_pstrb),         32'hF);
        check("wr_pwdata",  su_pwdata,             32'hA5A5_5A5A);
        check("wr_access",  32'(pen_total - e0),   32'd1);
        step();
        @(negedge clk);
        check("wr_rvalid_drop", 32'(obi.obi_rvalid_o), 32'd0);
        step();

        // Read with two wait states
        e0 = pen_total;
        slv_ws = 2;
        apb.prdata_i = 32'h1234_5678;
        issue(32'h0101_0FFC, 1'b0, 4'hF, 32'hFFFF_FFFF, 1'b1);
        wait_resp(20, lat);
        check("rd_latency", 32'(lat),             32'd5);
        check("rd_rdata",   obi.obi_rdata_o,      32'h1234_5678);
        check("rd_rid",     32'(obi.obi_rid_o),   32'd1);
        check("rd_err",     32'(obi.obi_err_o),   32'd0);
        check("rd_paddr",   32'(su_paddr),        32'hFFC);
        check("rd_pwrite",  32'(su_pwrite),       32'd0);
        check("rd_pstrb",   32'(su_pstrb),        32'd0);
        check("rd_access",  32'(pen_total - e0),  32'd3);
        step();

        // Out of window
        p0 = psel_total;
        slv_ws = 0;
        issue(32'h0200_0000, 1'b1, 4'hF, 32'h1111_2222, 1'b0);
        wait_resp(20, lat);
        check("oow_latency", 32'(lat),             32'd1);
        check("oow_err",     32'(obi.obi_err_o),   32'd1);
        check("oow_rdata",   obi.obi_rdata_o,      32'd0);
        step();
        @(negedge clk);
        check("oow_no_psel", 32'(psel_total - p0), 32'd0);
        step();

        // Slave error with response backpressure and a pending request
        apb.prdata_i  = 32'hDEAD_BEEF;
        apb.pslverr_i = 1'b1;
        obi.obi_rready_i = 1'b0;
        issue(32'h0101_0004, 1'b0, 4'hF, 32'h0, 1'b1);
        wait_resp(20, lat);
        check("se_latency", 32'(lat), 32'd3);
        obi.obi_req_i   = 1'b1;
        obi.obi_addr_i  = 32'h0101_0020;
        obi.obi_we_i    = 1'b1;
        obi.obi_be_i    = 4'h3;
        obi.obi_wdata_i = 32'h0000_00C3;
        obi.obi_aid_i   = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) begin
                step();
                if (k == 4) obi.obi_rready_i = 1'b1;
                @(negedge clk);
            end
            check("se_rvalid", 32'(obi.obi_rvalid_o), 32'd1);
            check("se_rdata",  obi.obi_rdata_o,       32'hDEAD_BEEF);
            check("se_err",    32'(obi.obi_err_o),    32'd1);
            check("se_gnt",    32'(obi.obi_gnt_o),    32'd0);
        end
        apb.pslverr_i = 1'b0;
        step();
        @(negedge clk);
        check("se_next_gnt", 32'(obi.obi_gnt_o), 32'd1);
        step();
        obi.obi_req_i = 1'b0;
        wait_resp(20, lat);
        check("se_next_latency", 32'(lat),            32'd3);
        check("se_next_err",     32'(obi.obi_err_o),  32'd0);
        check("se_next_pstrb",   32'(su_pstrb),       32'h3);
        check("se_next_pwdata",  su_pwdata,           32'h0000_00C3);
        step();

        // Timeout after 8 ACCESS cycles
        e0 = pen_total;
        slv_hang = 1'b1;
        apb.prdata_i = 32'h5555_AAAA;
        issue(32'h0101_0100, 1'b0, 4'hF, 32'h0, 1'b0);
        wait_resp(30, lat);
        check("to_latency", 32'(lat),            32'd10);
        check("to_err",     32'(obi.obi_err_o),  32'd1);
        check("to_rdata",   obi.obi_rdata_o,     32'd0);
        check("to_access",  32'(pen_total - e0), 32'd8);
        check("to_psel",    32'(apb.psel_o),     32'd0);
        step();

        // Reset in the middle of ACCESS
        issue(32'h0101_0200, 1'b0, 4'hF, 32'h0, 1'b0);
        step();
        @(negedge clk);
        check("mr_penable_pre", 32'(apb.penable_o), 32'd1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        slv_hang = 1'b0;
        @(negedge clk);
        check("mr_psel",    32'(apb.psel_o),       32'd0);
        check("mr_penable", 32'(apb.penable_o),    32'd0);
        check("mr_rvalid",  32'(obi.obi_rvalid_o), 32'd0);
        check("mr_gnt",     32'(obi.obi_gnt_o),    32'd0);
        step();
        issue(32'h0101_0ABE, 1'b1, 4'hC, 32'h0BAD_F00D, 1'b1);
        wait_resp(20, lat);
        check("mr_latency", 32'(lat),           32'd3);
        check("mr_err",     32'(obi.obi_err_o), 32'd0);
        check("mr_rid",     32'(obi.obi_rid_o), 32'd1);
        check("mr_paddr",   32'(su_paddr),      32'hABC);
        check("mr_pstrb",   32'(su_pstrb),      32'hC);
        step();

        // Timeout disabled: waits well past 255 cycles, then completes
        obi2.obi_req_i  = 1'b1;
        obi2.obi_addr_i = 32'h0101_0008;
        obi2.obi_we_i   = 1'b0;
        obi2.obi_be_i   = 4'hF;
        obi2.obi_aid_i  = 1'b1;
        @(negedge clk);
        check("nto_gnt", 32'(obi2.obi_gnt_o), 32'd1);
        step();
        obi2.obi_req_i = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            step();
            @(negedge clk);
            if (obi2.obi_rvalid_o) seen = 1'b1;
        end
        check("nto_no_rvalid", 32'(seen),            32'd0);
        check("nto_penable",   32'(apb2.penable_o),  32'd1);
        apb2.prdata_i = 32'h0F0F_0F0F;
        apb2.pready_i = 1'b1;
        step();
        apb2.pready_i = 1'b0;
        @(negedge clk);
        check("nto_rvalid", 32'(obi2.obi_rvalid_o), 32'd1);
        check("nto_rdata",  obi2.obi_rdata_o,       32'h0F0F_0F0F);
        check("nto_err",    32'(obi2.obi_err_o),    32'd0);
        check("nto_rid",    32'(obi2.obi_rid_o),    32'd1);
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
